// File: rtl/acquisition_sequencer.sv
// Acquisition sequencer: runs START/STOP/SET_FRAMES host commands through an
// IDLE -> ARM -> ACQUIRE -> UPLOAD frame loop with an upload watchdog.
module acquisition_sequencer #(
  parameter int DEFAULT_INTG   = 5000,
  parameter int INTG_SHIFT     = 2,
  parameter int UPLOAD_TIMEOUT = 1000000
) (
  input  logic        clk_in,
  input  logic        reset_n,
  input  logic [15:0] cmd_word,
  input  logic        cmd_valid,
  input  logic        frame_done,
  input  logic        upload_done,
  output logic        running,
  output logic        frame_start,
  output logic [31:0] integration_clock_count,
  output logic [15:0] frame_count,
  output logic        run_done,
  output logic        cmd_error,
  output logic        upload_timeout
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    ACQUIRE = 2'd2,
    UPLOAD  = 2'd3
  } state_t;

  localparam logic [1:0] OP_START = 2'b01;
  localparam logic [1:0] OP_STOP  = 2'b10;
  localparam logic [1:0] OP_SETF  = 2'b11;
  localparam int         WD_W     = $clog2(UPLOAD_TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(UPLOAD_TIMEOUT - 1);

  state_t           state, state_n;
  logic             frame_start_n, run_done_n;
  logic [15:0]      frame_count_n;
  logic [13:0]      frame_limit, frame_limit_n;
  logic             stop_pending, stop_pending_n;
  logic             cmd_error_n, upload_timeout_n;
  logic [31:0]      intg_n;
  logic [WD_W-1:0]  wd, wd_n;

  logic [1:0]  op;
  logic [13:0] val;
  logic        is_start, is_stop, is_setf;

  assign op       = cmd_word[15:14];
  assign val      = cmd_word[13:0];
  assign is_start = cmd_valid && (op == OP_START);
  assign is_stop  = cmd_valid && (op == OP_STOP);
  assign is_setf  = cmd_valid && (op == OP_SETF);
  assign running  = (state != IDLE);

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state                   <= IDLE;
      frame_start             <= 1'b0;
      run_done                <= 1'b0;
      frame_count             <= '0;
      frame_limit             <= '0;
      stop_pending            <= 1'b0;
      cmd_error               <= 1'b0;
      upload_timeout          <= 1'b0;
      integration_clock_count <= 32'(DEFAULT_INTG);
      wd                      <= '0;
    end else begin
      state                   <= state_n;
      frame_start             <= frame_start_n;
      run_done                <= run_done_n;
      frame_count             <= frame_count_n;
      frame_limit             <= frame_limit_n;
      stop_pending            <= stop_pending_n;
      cmd_error               <= cmd_error_n;
      upload_timeout          <= upload_timeout_n;
      integration_clock_count <= intg_n;
      wd                      <= wd_n;
    end
  end

  always_comb begin
    state_n          = state;
    frame_start_n    = 1'b0;
    run_done_n       = 1'b0;
    frame_count_n    = frame_count;
    frame_limit_n    = frame_limit;
    stop_pending_n   = stop_pending;
    cmd_error_n      = cmd_error;
    upload_timeout_n = upload_timeout;
    intg_n           = integration_clock_count;
    wd_n             = wd;

    // Commands that are illegal mid-run only flag an error; STOP is deferred
    if (state != IDLE) begin
      if (is_start || is_setf) cmd_error_n = 1'b1;
      if (is_stop) stop_pending_n = 1'b1;
    end

    case (state)
      IDLE: begin
        if (is_start) begin
          if (val != 14'd0) begin
            intg_n           = 32'(val) << INTG_SHIFT;
            frame_count_n    = '0;
            stop_pending_n   = 1'b0;
            cmd_error_n      = 1'b0;
            upload_timeout_n = 1'b0;
            state_n          = ARM;
          end else begin
            cmd_error_n = 1'b1;
          end
        end
        if (is_setf) frame_limit_n = val;
      end
      ARM: begin
        frame_start_n = 1'b1;
        state_n       = ACQUIRE;
      end
      ACQUIRE: begin
        if (frame_done) begin
          frame_count_n = frame_count + 16'd1;
          wd_n          = '0;
          state_n       = UPLOAD;
        end
      end
      UPLOAD: begin
        // A STOP arriving with upload_done still ends the run on this edge
        if (upload_done) begin
          if (stop_pending || is_stop ||
              ((frame_limit != 14'd0) && (frame_count == {2'b00, frame_limit}))) begin
            state_n        = IDLE;
            run_done_n     = 1'b1;
            stop_pending_n = 1'b0;
          end else begin
            state_n = ARM;
          end
        end else if (wd == WD_LAST) begin
          upload_timeout_n = 1'b1;
          run_done_n       = 1'b1;
          stop_pending_n   = 1'b0;
          state_n          = IDLE;
        end else begin
          wd_n = wd + WD_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_acquisition_sequencer.sv
// Self-checking bench for acquisition_sequencer: table-driven per-cycle vectors
// through an expected-value queue, plus watchdog and mid-run reset sequences.
module tb_acquisition_sequencer;

  typedef struct {
    logic        cv;
    logic [15:0] word;
    logic        fd;
    logic        ud;
    logic        running;
    logic        fs;
    logic        rd;
    logic [15:0] fc;
    logic [31:0] icc;
    logic        err;
    logic        to;
  } vec_t;

  logic        clk_in;
  logic        reset_n;
  logic [15:0] cmd_word;
  logic        cmd_valid;
  logic        frame_done;
  logic        upload_done;
  logic        running;
  logic        frame_start;
  logic [31:0] integration_clock_count;
  logic [15:0] frame_count;
  logic        run_done;
  logic        cmd_error;
  logic        upload_timeout;

  int checks;
  int errors;
  vec_t sb_q[$];
  vec_t vecs[30];

  acquisition_sequencer #(
    .DEFAULT_INTG(5000),
    .INTG_SHIFT(2),
    .UPLOAD_TIMEOUT(16)
  ) dut (
    .clk_in(clk_in),
    .reset_n(reset_n),
    .cmd_word(cmd_word),
    .cmd_valid(cmd_valid),
    .frame_done(frame_done),
    .upload_done(upload_done),
    .running(running),
    .frame_start(frame_start),
    .integration_clock_count(integration_clock_count),
    .frame_count(frame_count),
    .run_done(run_done),
    .cmd_error(cmd_error),
    .upload_timeout(upload_timeout)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  function automatic vec_t mk(input logic cv, input logic [15:0] word,
                              input logic fd, input logic ud,
                              input logic run, input logic fs, input logic rd,
                              input logic [15:0] fc, input logic [31:0] icc,
                              input logic err, input logic to);
    vec_t v;
    v.cv = cv; v.word = word; v.fd = fd; v.ud = ud;
    v.running = run; v.fs = fs; v.rd = rd; v.fc = fc;
    v.icc = icc; v.err = err; v.to = to;
    return v;
  endfunction

  task automatic check_field(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_output(input string tag);
    vec_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: scoreboard empty got %0d expected 1 entry", tag, sb_q.size());
      return;
    end
    e = sb_q.pop_front();
    check_field({tag, ".running"}, 32'(running), 32'(e.running));
    check_field({tag, ".frame_start"}, 32'(frame_start), 32'(e.fs));
    check_field({tag, ".run_done"}, 32'(run_done), 32'(e.rd));
    check_field({tag, ".frame_count"}, 32'(frame_count), 32'(e.fc));
    check_field({tag, ".intg"}, integration_clock_count, e.icc);
    check_field({tag, ".cmd_error"}, 32'(cmd_error), 32'(e.err));
    check_field({tag, ".upload_timeout"}, 32'(upload_timeout), 32'(e.to));
  endtask

  task automatic apply_stimulus(input vec_t v, input string tag);
    @(negedge clk_in);
    cmd_valid   = v.cv;
    cmd_word    = v.word;
    frame_done  = v.fd;
    upload_done = v.ud;
    sb_q.push_back(v);
    @(posedge clk_in);
    #1;
    check_output(tag);
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    reset_n     = 1'b0;
    cmd_valid   = 1'b0;
    cmd_word    = 16'h0;
    frame_done  = 1'b0;
    upload_done = 1'b0;

    // Frame-limited run, bad START, free-run with STOP, START while running
    vecs[0]  = mk(0, 16'h0000, 0, 0, 0, 0, 0, 0, 5000, 0, 0);
    vecs[1]  = mk(1, 16'hC003, 0, 0, 0, 0, 0, 0, 5000, 0, 0);
    vecs[2]  = mk(1, 16'h44E2, 0, 0, 1, 0, 0, 0, 5000, 0, 0);
    vecs[3]  = mk(0, 16'h0000, 0, 0, 1, 1, 0, 0, 5000, 0, 0);
    vecs[4]  = mk(0, 16'h0000, 0, 1, 1, 0, 0, 0, 5000, 0, 0);
    vecs[5]  = mk(0, 16'h0000, 1, 0, 1, 0, 0, 1, 5000, 0, 0);
    vecs[6]  = mk(0, 16'h0000, 1, 0, 1, 0, 0, 1, 5000, 0, 0);
    vecs[7]  = mk(0, 16'h0000, 0, 1, 1, 0, 0, 1, 5000, 0, 0);
    vecs[8]  = mk(0, 16'h0000, 0, 0, 1, 1, 0, 1, 5000, 0, 0);
    vecs[9]  = mk(0, 16'h0000, 1, 0, 1, 0, 0, 2, 5000, 0, 0);
    vecs[10] = mk(0, 16'h0000, 0, 1, 1, 0, 0, 2, 5000, 0, 0);
    vecs[11] = mk(0, 16'h0000, 0, 0, 1, 1, 0, 2, 5000, 0, 0);
    vecs[12] = mk(0, 16'h0000, 1, 0, 1, 0, 0, 3, 5000, 0, 0);
    vecs[13] = mk(0, 16'h0000, 0, 1, 0, 0, 1, 3, 5000, 0, 0);
    vecs[14] = mk(0, 16'h0000, 0, 0, 0, 0, 0, 3, 5000, 0, 0);
    vecs[15] = mk(1, 16'h4000, 0, 0, 0, 0, 0, 3, 5000, 1, 0);
    vecs[16] = mk(1, 16'hC000, 0, 0, 0, 0, 0, 3, 5000, 1, 0);
    vecs[17] = mk(1, 16'h400A, 0, 0, 1, 0, 0, 0, 40, 0, 0);
    vecs[18] = mk(0, 16'h0000, 0, 0, 1, 1, 0, 0, 40, 0, 0);
    vecs[19] = mk(1, 16'h8000, 0, 0, 1, 0, 0, 0, 40, 0, 0);
    vecs[20] = mk(0, 16'h0000, 1, 0, 1, 0, 0, 1, 40, 0, 0);
    vecs[21] = mk(0, 16'h0000, 0, 1, 0, 0, 1, 1, 40, 0, 0);
    vecs[22] = mk(0, 16'h0000, 0, 0, 0, 0, 0, 1, 40, 0, 0);
    vecs[23] = mk(1, 16'h400A, 0, 0, 1, 0, 0, 0, 40, 0, 0);
    vecs[24] = mk(1, 16'h4064, 0, 0, 1, 1, 0, 0, 40, 1, 0);
    vecs[25] = mk(0, 16'h0000, 1, 0, 1, 0, 0, 1, 40, 1, 0);
    vecs[26] = mk(1, 16'h8000, 0, 1, 0, 0, 1, 1, 40, 1, 0);
    vecs[27] = mk(0, 16'h0000, 0, 0, 0, 0, 0, 1, 40, 1, 0);
    vecs[28] = mk(1, 16'h8000, 0, 0, 0, 0, 0, 1, 40, 1, 0);
    vecs[29] = mk(0, 16'h0000, 1, 1, 0, 0, 0, 1, 40, 1, 0);

    repeat (2) @(negedge clk_in);
    check_field("reset.running", 32'(running), 32'd0);
    check_field("reset.intg", integration_clock_count, 32'd5000);
    check_field("reset.frame_count", 32'(frame_count), 32'd0);
    reset_n = 1'b1;

    for (int i = 0; i < 30; i++)
      apply_stimulus(vecs[i], $sformatf("vec%0d", i));

    // Watchdog: withheld upload_done aborts after 16 cycles in UPLOAD
    apply_stimulus(mk(1, 16'h4001, 0, 0, 1, 0, 0, 0, 4, 0, 0), "wd_start");
    apply_stimulus(mk(0, 16'h0000, 0, 0, 1, 1, 0, 0, 4, 0, 0), "wd_arm");
    apply_stimulus(mk(0, 16'h0000, 1, 0, 1, 0, 0, 1, 4, 0, 0), "wd_fd");
    for (int i = 0; i < 15; i++)
      apply_stimulus(mk(0, 16'h0000, 0, 0, 1, 0, 0, 1, 4, 0, 0), $sformatf("wd_wait%0d", i));
    apply_stimulus(mk(0, 16'h0000, 0, 0, 0, 0, 1, 1, 4, 0, 1), "wd_expire");
    apply_stimulus(mk(0, 16'h0000, 0, 0, 0, 0, 0, 1, 4, 0, 1), "wd_after");

    // Reset asserted during ACQUIRE of the second frame
    apply_stimulus(mk(1, 16'h4005, 0, 0, 1, 0, 0, 0, 20, 0, 0), "rst_start");
    apply_stimulus(mk(0, 16'h0000, 0, 0, 1, 1, 0, 0, 20, 0, 0), "rst_arm");
    apply_stimulus(mk(0, 16'h0000, 1, 0, 1, 0, 0, 1, 20, 0, 0), "rst_fd");
    apply_stimulus(mk(0, 16'h0000, 0, 1, 1, 0, 0, 1, 20, 0, 0), "rst_ud");
    apply_stimulus(mk(0, 16'h0000, 0, 0, 1, 1, 0, 1, 20, 0, 0), "rst_arm2");
    apply_stimulus(mk(1, 16'h4007, 0, 0, 1, 0, 0, 1, 20, 1, 0), "rst_badstart");
    @(negedge clk_in);
    cmd_valid = 1'b0;
    reset_n   = 1'b0;
    #1;
    check_field("midrst.running", 32'(running), 32'd0);
    check_field("midrst.frame_start", 32'(frame_start), 32'd0);
    check_field("midrst.run_done", 32'(run_done), 32'd0);
    check_field("midrst.frame_count", 32'(frame_count), 32'd0);
    check_field("midrst.intg", integration_clock_count, 32'd5000);
    check_field("midrst.cmd_error", 32'(cmd_error), 32'd0);
    check_field("midrst.upload_timeout", 32'(upload_timeout), 32'd0);
    @(posedge clk_in);
    #1;
    check_field("midrst.run_done_edge", 32'(run_done), 32'd0);
    @(negedge clk_in);
    reset_n = 1'b1;
    apply_stimulus(mk(0, 16'h0000, 1, 0, 0, 0, 0, 0, 5000, 0, 0), "post_fd");
    apply_stimulus(mk(0, 16'h0000, 0, 1, 0, 0, 0, 0, 5000, 0, 0), "post_ud");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/acquisition_sequencer.md
ACQUISITION_SEQUENCER -- requirements
Module: acquisition_sequencer

Interface
REQ-001 SHALL have parameter DEFAULT_INTG, 5000, integration_clock_count value after reset.
REQ-002 SHALL have parameter INTG_SHIFT, 2, left shift applied to the command value to form integration_clock_count.
REQ-003 SHALL have parameter UPLOAD_TIMEOUT, 1000000, clk_in cycles allowed in UPLOAD before abort.
REQ-004 SHALL have port clk_in, input, 1, single system clock; all logic on its rising edge.
REQ-005 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port cmd_word, input, 16, host command: op [15:14], val [13:0].
REQ-007 SHALL have port cmd_valid, input, 1, one-cycle strobe qualifying cmd_word.
REQ-008 SHALL have port frame_done, input, 1, one-cycle pulse from readout controller at end of frame readout.
REQ-009 SHALL have port upload_done, input, 1, one-cycle pulse from USB controller when the frame has been transferred.
REQ-010 SHALL have port running, output, 1, high in every state except IDLE.
REQ-011 SHALL have port frame_start, output, 1, one-cycle pulse starting one frame.
REQ-012 SHALL have port integration_clock_count, output, 32, integration length in clk_in cycles.
REQ-013 SHALL have port frame_count, output, 16, frames completed in the current run.
REQ-014 SHALL have port run_done, output, 1, one-cycle pulse on return to IDLE from a run.
REQ-015 SHALL have port cmd_error, output, 1, sticky; rejected command.
REQ-016 SHALL have port upload_timeout, output, 1, sticky; UPLOAD watchdog expired.

Function
REQ-017 SHALL decode op: 00 NOOP, 01 START, 10 STOP, 11 SET_FRAMES; cmd_word ignored when cmd_valid low.
REQ-018 SHALL implement states IDLE, ARM, ACQUIRE, UPLOAD.
REQ-019 IDLE: START with val!=0 SHALL load integration_clock_count = zero-extended val << INTG_SHIFT, clear frame_count, stop_pending, cmd_error, upload_timeout, and go to ARM next cycle.
REQ-020 IDLE: START with val==0 SHALL set cmd_error and remain in IDLE, integration_clock_count unchanged.
REQ-021 IDLE: SET_FRAMES SHALL load 14-bit frame_limit = val; frame_limit 0 = free-run.
REQ-022 ARM: SHALL assert frame_start for exactly that one cycle, then enter ACQUIRE.
REQ-023 ACQUIRE: on frame_done SHALL increment frame_count (16-bit, wraps FFFF->0000) and enter UPLOAD; upload_done in ACQUIRE SHALL be ignored.
REQ-024 UPLOAD: on upload_done SHALL go to IDLE with run_done pulse if stop_pending or (frame_limit!=0 and frame_count==frame_limit), else to ARM.
REQ-025 UPLOAD: watchdog counter SHALL clear on UPLOAD entry; reaching UPLOAD_TIMEOUT SHALL set upload_timeout and go to IDLE with run_done pulse.
REQ-026 STOP in ARM, ACQUIRE or UPLOAD SHALL set stop_pending; current frame SHALL complete; STOP in IDLE SHALL be a no-op.
REQ-027 START or SET_FRAMES outside IDLE SHALL set cmd_error and be otherwise ignored; NOOP SHALL never change state.
REQ-028 frame_done outside ACQUIRE and upload_done outside UPLOAD SHALL be ignored.
REQ-029 STOP arriving in the same cycle as upload_done SHALL end the run in that transition.
REQ-030 frame_start, run_done SHALL be registered outputs; frame_start occurs one cycle after entering ARM is decided (START accept -> frame_start two clk_in edges later).

Reset
REQ-031 reset_n low SHALL immediately force IDLE, running 0, frame_start 0, run_done 0, frame_count 0, frame_limit 0, stop_pending 0, cmd_error 0, upload_timeout 0, integration_clock_count DEFAULT_INTG, watchdog 0.
REQ-032 Reset asserted mid-run SHALL abort without run_done pulse.

Verification
REQ-033 SET_FRAMES val=3, START val=1250 -> integration_clock_count 5000, three frame_start pulses each after upload_done, frame_count 3, one run_done, running low.
REQ-034 START val=0 in IDLE -> cmd_error 1, running 0, integration_clock_count stays 5000.
REQ-035 Free-run START val=10, STOP during ACQUIRE -> no new frame_start after that frame's upload_done; run_done once; integration_clock_count 40.
REQ-036 START while running -> cmd_error 1, run continues, integration_clock_count unchanged.
REQ-037 UPLOAD_TIMEOUT=16, withhold upload_done -> upload_timeout 1 after 16 cycles in UPLOAD, IDLE, run_done pulse.
REQ-038 reset_n low during ACQUIRE -> all outputs at reset values same cycle, no run_done; frame_done afterwards ignored.
